// File: rtl/op_dispatch_queue.sv
// Op-code dispatch queue: filters undefined op codes and buffers legal ones
// in a small FIFO feeding the ALU stage, with illegal-code accounting and flush.
module op_dispatch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [2:0]                 in_op,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2:0]                 op_code,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       illegal_seen,
   output logic [ERR_CNT_W-1:0]       err_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [2:0]  OpUndef = 3'd7;

   logic [2:0]           mem_q [DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 illegal_seen_q, illegal_seen_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

   logic accept, push, drop, pop;

   assign in_ready  = (count_q < CntW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && (in_op != OpUndef);
   assign drop      = accept && (in_op == OpUndef);
   // in_ready already blocks accepts during flush; pops must be masked explicitly
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      illegal_seen_d = illegal_seen_q;
      err_count_d    = err_count_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end

      if (drop) begin
         illegal_seen_d = 1'b1;
         if (err_count_q != {ERR_CNT_W{1'b1}}) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         illegal_seen_q <= 1'b0;
         err_count_q    <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         illegal_seen_q <= illegal_seen_d;
         err_count_q    <= err_count_d;
      end
   end

   // Storage needs no reset: stale entries are never visible while count is zero.
   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         mem_q[wr_ptr_q] <= in_op;
      end
   end

   assign op_code      = out_valid ? mem_q[rd_ptr_q] : 3'd0;
   assign count        = count_q;
   assign illegal_seen = illegal_seen_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_op_dispatch_queue.sv
// Randomized and directed bench for op_dispatch_queue, checked against a
// queue-based reference model of the dispatch rules.
module tb_op_dispatch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned ERR_W = 2;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [2:0]       in_op = 3'd0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2:0]       op_code;
   logic [CW-1:0]    count;
   logic             illegal_seen;
   logic [ERR_W-1:0] err_count;

   op_dispatch_queue #(
      .DEPTH     (DEPTH),
      .ERR_CNT_W (ERR_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_op        (in_op),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .op_code      (op_code),
      .count        (count),
      .illegal_seen (illegal_seen),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   int q[$];
   int m_err  = 0;
   bit m_seen = 1'b0;
   int err_max = (1 << ERR_W) - 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Drive one cycle of inputs, compare outputs to the model, then advance the model.
   task automatic step(input bit r, input bit f, input bit iv, input int op, input bit ordy);
      bit ready;
      @(negedge clk);
      reset_n   = r;
      flush     = f;
      in_valid  = iv;
      in_op     = op[2:0];
      out_ready = ordy;
      #1;
      ready = (q.size() < DEPTH) && !f;
      check("in_ready", {31'd0, in_ready}, {31'd0, ready});
      check("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 1 : 0);
      check("op_code", {29'd0, op_code}, (q.size() != 0) ? q[0] : 0);
      check("count", 32'(count), q.size());
      check("illegal_seen", {31'd0, illegal_seen}, {31'd0, m_seen});
      check("err_count", 32'(err_count), m_err);
      @(posedge clk);
      if (!r) begin
         q.delete();
         m_err  = 0;
         m_seen = 1'b0;
      end else if (f) begin
         q.delete();
      end else begin
         if (ordy && q.size() != 0) void'(q.pop_front());
         if (iv && ready) begin
            if (op != 7) q.push_back(op);
            else begin
               m_seen = 1'b1;
               if (m_err < err_max) m_err++;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      step(0, 0, 0, 0, 0);

      // Fill with 0..3, try one more while full, then drain in order
      for (int k = 0; k < 4; k++) step(1, 0, 1, k, 0);
      step(1, 0, 1, 2, 0);
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1);
      idle(1);

      // Illegal code in the middle of a stream leaves no gap
      step(1, 0, 1, 5, 1);
      step(1, 0, 1, 7, 1);
      step(1, 0, 1, 6, 1);
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1);

      // Code 7 offered while full is neither consumed nor counted
      for (int k = 1; k <= 4; k++) step(1, 0, 1, k, 0);
      for (int k = 0; k < 3; k++) step(1, 0, 1, 7, 0);
      step(1, 0, 0, 0, 1);
      idle(1);

      // Simultaneous push and pop at count=2
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1);
      step(1, 0, 1, 1, 0);
      step(1, 0, 1, 2, 0);
      step(1, 0, 1, 4, 1);
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1);

      // Flush with a pending input and pop request
      for (int k = 0; k < 3; k++) step(1, 0, 1, 3, 0);
      step(1, 1, 1, 1, 1);
      idle(2);

      // Error counter saturation, then reset takes effect on the edge only
      step(0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) step(1, 0, 1, 7, 0);
      step(1, 0, 1, 6, 0);
      step(0, 0, 0, 0, 0);
      idle(2);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0) ? 7 : $urandom_range(0, 6),
              ($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
